multicycle_control: RTL and testbench

Main control FSM for the multicycle MIPS datapath. It decodes the 6-bit instruction opcode across fetch, decode, execute, memory and writeback states and drives every datapath enable, including the 2-bit `ALUOp` consumed by the ALU control decoder (00 add, 01 sub, 10 use funct). The FSM stalls on a memory-ready handshake and flags unsupported opcodes.

---
 rtl/multicycle_control.sv | 162 ++++++++++++++++
 tb/tb_multicycle_control.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/
// execute/memory/writeback and drives every datapath enable from the current state.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_reg, state_next;
  logic   illegal_reg;
  logic   illegal_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= FETCH;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (illegal_set)
        illegal_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next  = FETCH;
    illegal_set = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    instr_done  = 1'b0;
    case (state_reg)
      FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = 2'b01;
        IRWrite    = mem_ready;
        PCWrite    = mem_ready;
        state_next = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // Branch target is precomputed here while the opcode is decoded
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXEC;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
          default: begin
            state_next  = FETCH;
            illegal_set = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead    = 1'b1;
        IorD       = 1'b1;
        state_next = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        state_next = mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = ADDIWB;
      end
      ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      default: state_next = FETCH;
    endcase
  end

  assign illegal_op = illegal_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expected state/controls are queued as
// each cycle is driven and popped/compared at the following falling edge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
  localparam logic [5:0] ILL = 6'b111111;

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctl;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   step = 0;
  logic exp_ill = 1'b0;

  // Bit order: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite
  // ALUSrcA RegWrite RegDst PCSource[2] ALUSrcB[2] ALUOp[2] instr_done illegal_op
  logic [17:0] obs_ctl;
  assign obs_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                    IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
                    ALUOp, instr_done, illegal_op};

  function automatic logic [17:0] exp_ctl(input logic [3:0] st, input logic mr,
                                          input logic ill);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, done;
    logic [1:0] pcs, asb, aop;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, done} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 2'b00;
    case (st)
      4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; done = 1; end
      4'd5:  begin mwr = 1; iord = 1; done = mr; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; done = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
      4'd9:  begin asa = 1; asb = 2'b10; end
      4'd10: begin rw = 1; done = 1; end
      4'd11: begin pcw = 1; pcs = 2'b10; done = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, pcs, asb, aop, done, ill};
  endfunction

  task automatic expect_now(input logic [3:0] st);
    exp_t e;
    e.st  = st;
    e.ctl = exp_ctl(st, mem_ready, exp_ill);
    sb.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    e = sb.pop_front();
    step++;
    vectors++;
    assert (state === e.st) else begin
      miscompares++;
      $error("FAIL state step%0d: got %0d expected %0d", step, state, e.st);
    end
    vectors++;
    assert (obs_ctl === e.ctl) else begin
      miscompares++;
      $error("FAIL ctl step%0d (state %0d): got %b expected %b", step, e.st, obs_ctl, e.ctl);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, check at the falling edge.
  task automatic cyc(input logic [5:0] opc, input logic mr, input logic [3:0] st);
    opcode    = opc;
    mem_ready = mr;
    expect_now(st);
    @(negedge clk);
    check_front();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; opcode = RT;
    #2;
    expect_now(4'd0); check_front();
    mem_ready = 1'b1; #1;
    expect_now(4'd0); check_front();
    mem_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // FETCH stall then go
    cyc(RT, 0, 0); cyc(RT, 0, 0); cyc(RT, 0, 0); cyc(RT, 1, 0);
    // R-type
    cyc(RT, 1, 1); cyc(RT, 1, 6); cyc(RT, 1, 7);
    // lw with two MEMRD stall cycles
    cyc(LW, 1, 0); cyc(LW, 1, 1); cyc(LW, 1, 2);
    cyc(LW, 0, 3); cyc(LW, 0, 3); cyc(LW, 1, 3); cyc(LW, 1, 4);
    // beq then j
    cyc(BEQ, 1, 0); cyc(BEQ, 1, 1); cyc(BEQ, 1, 8);
    cyc(J, 1, 0); cyc(J, 1, 1); cyc(J, 1, 11);
    // illegal opcode, then addi with sticky flag
    cyc(ILL, 1, 0); cyc(ILL, 1, 1);
    exp_ill = 1'b1;
    cyc(ADDI, 1, 0); cyc(ADDI, 1, 1); cyc(ADDI, 1, 9); cyc(ADDI, 1, 10);
    // sw completing immediately
    cyc(SW, 1, 0); cyc(SW, 1, 1); cyc(SW, 1, 2); cyc(SW, 1, 5);
    // sw stalled in MEMWR, then asynchronous reset mid-instruction
    cyc(SW, 1, 0); cyc(SW, 1, 1); cyc(SW, 1, 2); cyc(SW, 0, 5); cyc(SW, 0, 5);
    #2;
    rst_n = 1'b0;
    exp_ill = 1'b0;
    #1;
    expect_now(4'd0); check_front();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(SW, 1, 0); cyc(SW, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
